// File: rtl/alu_pkg.sv
// Shared ALU definitions.
// Holds the 3-bit ALU control codes (also used by the ALU control decoder)
// and the state encoding of the multi-cycle execute FSM.
package alu_pkg;

    // ALU control codes
    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_XOR  = 3'b001;
    localparam logic [2:0] ALU_SLL  = 3'b010;
    localparam logic [2:0] ALU_ADD  = 3'b011;
    localparam logic [2:0] ALU_SUB  = 3'b100;
    localparam logic [2:0] ALU_MUL  = 3'b101;
    localparam logic [2:0] ALU_ADDI = 3'b110;
    localparam logic [2:0] ALU_SRAI = 3'b111;

    // Execute FSM states
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_MUL  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/mul_shift_add.sv
// Iterative shift-add multiplier, one partial product per cycle.
// Ports:
//   clk_i, rst_i  clock / async active-high reset
//   start_i       latch a_i, b_i, clear accumulator and counter, begin
//   abort_i       drop the operation in flight (wins over start_i)
//   a_i, b_i      operands
//   busy_o        an operation is iterating
//   done_o        this cycle performs the final iteration
//   prod_o        accumulator value after this cycle's iteration; equals the
//                 final low-WIDTH product while done_o is high
module mul_shift_add #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] prod_o
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] a_q, b_q, acc_q, acc_nxt;
    logic [CW-1:0]    cnt_q;

    assign acc_nxt = b_q[0] ? acc_q + a_q : acc_q;
    // Exposing the next accumulator lets the caller register the product on
    // the same edge as the last iteration, saving a cycle of latency.
    assign prod_o  = acc_nxt;
    assign done_o  = busy_o && (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_o <= 1'b0;
        end else if (abort_i) begin
            busy_o <= 1'b0;
        end else if (start_i) begin
            a_q    <= a_i;
            b_q    <= b_i;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_o <= 1'b1;
        end else if (busy_o) begin
            acc_q <= acc_nxt;
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
            cnt_q <= cnt_q + CW'(1);
            if (done_o)
                busy_o <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU with a multi-cycle multiplier.
// Single-cycle ops produce a result one edge after accept; MUL iterates in
// mul_shift_add and produces its result WIDTH+1 edges after accept.
// Ports:
//   clk_i, rst_i          clock / async active-high reset
//   valid_i, ready_o      request handshake (accept = valid_i && ready_o)
//   ALUCtrl_i             3-bit operation code (alu_pkg codes)
//   data1_i, data2_i      operands A and B
//   flush_i               abort any op in flight; blocks accept this cycle
//   valid_o               one-cycle pulse marking a new result
//   data_o, zero_o        result and its zero flag, held between results
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [2:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic             flush_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             zero_o
);
    localparam int CW = $clog2(WIDTH);

    logic [1:0]       state_q;
    logic [WIDTH-1:0] alu_res;
    logic [CW-1:0]    shamt;
    logic             accept, is_mul;
    logic             mul_busy, mul_done;
    logic [WIDTH-1:0] mul_prod;

    // ready_o depends only on registered state, never on valid_i.
    assign ready_o = (state_q == ST_IDLE) && !mul_busy;
    assign accept  = valid_i && ready_o && !flush_i;
    assign is_mul  = (ALUCtrl_i == ALU_MUL);
    assign shamt   = data2_i[CW-1:0];

    always_comb begin
        alu_res = '0;
        case (ALUCtrl_i)
            ALU_AND:            alu_res = data1_i & data2_i;
            ALU_XOR:            alu_res = data1_i ^ data2_i;
            ALU_SLL:            alu_res = data1_i << shamt;
            ALU_ADD, ALU_ADDI:  alu_res = data1_i + data2_i;
            ALU_SUB:            alu_res = data1_i - data2_i;
            ALU_SRAI:           alu_res = $signed(data1_i) >>> shamt;
            default:            alu_res = '0;
        endcase
    end

    mul_shift_add #(.WIDTH(WIDTH)) u_mul (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (accept && is_mul),
        .abort_i (flush_i),
        .a_i     (data1_i),
        .b_i     (data2_i),
        .busy_o  (mul_busy),
        .done_o  (mul_done),
        .prod_o  (mul_prod)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            valid_o <= 1'b0;
            data_o  <= '0;
            zero_o  <= 1'b1;
        end else begin
            valid_o <= 1'b0;
            if (flush_i) begin
                // Outputs keep their last result; any pending result is lost.
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (accept) begin
                            if (is_mul) begin
                                state_q <= ST_MUL;
                            end else begin
                                data_o  <= alu_res;
                                zero_o  <= (alu_res == '0);
                                valid_o <= 1'b1;
                            end
                        end
                    end
                    ST_MUL: begin
                        // Register the product on the final iteration edge so
                        // the DONE cycle already presents it.
                        if (mul_done) begin
                            data_o  <= mul_prod;
                            zero_o  <= (mul_prod == '0);
                            valid_o <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                    ST_DONE: state_q <= ST_IDLE;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (WIDTH=32): directed table,
// multi-cycle corner sequences and randomized ops against a reference model.
module tb_alu_multicycle;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid_i;
    logic [2:0]   ctrl;
    logic [W-1:0] d1, d2;
    logic         flush;
    logic         ready, valid_o, zero;
    logic [W-1:0] data;

    int checks = 0;
    int errors = 0;

    alu_multicycle #(.WIDTH(W)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .valid_i   (valid_i),
        .ALUCtrl_i (ctrl),
        .data1_i   (d1),
        .data2_i   (d2),
        .flush_i   (flush),
        .ready_o   (ready),
        .valid_o   (valid_o),
        .data_o    (data),
        .zero_o    (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain arithmetic on the operation definitions.
    function automatic logic [W-1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] p;
        case (op)
            ALU_AND:  return a & b;
            ALU_XOR:  return a ^ b;
            ALU_SLL:  return a << b[4:0];
            ALU_ADD:  return a + b;
            ALU_ADDI: return a + b;
            ALU_SUB:  return a - b;
            ALU_MUL:  begin p = 64'(a) * 64'(b); return p[31:0]; end
            default:  return $signed(a) >>> b[4:0];
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, then measure latency, busy time and the result pulse.
    task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input string nm);
        logic [W-1:0] exp;
        int lat, nrdy, n, explat;
        exp    = ref_alu(op, a, b);
        explat = (op == ALU_MUL) ? W + 1 : 1;
        n = 0;
        while (!ready && n < 100) begin tick(); n++; end
        valid_i = 1'b1; ctrl = op; d1 = a; d2 = b;
        tick();
        valid_i = 1'b0;
        lat = 1; nrdy = 0;
        while (!valid_o && lat < 100) begin
            if (!ready) nrdy++;
            tick();
            lat++;
        end
        if (!ready) nrdy++;
        chk({nm, " latency"}, lat, explat);
        chk({nm, " busy cycles"}, nrdy, (op == ALU_MUL) ? W + 1 : 0);
        chk({nm, " data"}, data, exp);
        chk({nm, " zero"}, W'(zero), W'(exp == '0));
        tick();
        chk({nm, " single pulse"}, W'(valid_o), 0);
    endtask

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] prev;
        int pulses, vcyc, nrdy;

        rst = 1'b1; valid_i = 1'b0; ctrl = '0; d1 = '0; d2 = '0; flush = 1'b0;
        #3;
        chk("por valid_o", W'(valid_o), 0);
        chk("por data_o", data, 0);
        chk("por zero_o", W'(zero), 1);
        chk("por ready_o", W'(ready), 1);
        #9 rst = 1'b0;
        tick();

        // 1: mid-cycle reset after a nonzero result
        do_op(ALU_ADD, 32'd7, 32'd5, "pre-reset add");
        #3 rst = 1'b1;
        #1;
        chk("reset valid_o", W'(valid_o), 0);
        chk("reset data_o", data, 0);
        chk("reset zero_o", W'(zero), 1);
        chk("reset ready_o", W'(ready), 1);
        @(posedge clk); #1 rst = 1'b0;
        tick();

        // 2: back-to-back single-cycle ops
        vecs[0] = '{ALU_ADD,  32'd7,          32'd5,      32'd12};
        vecs[1] = '{ALU_SUB,  32'd5,          32'd7,      32'hFFFF_FFFE};
        vecs[2] = '{ALU_AND,  32'h0000_F0F0,  32'h0000_FF00, 32'h0000_F000};
        vecs[3] = '{ALU_XOR,  32'h0000_00AA,  32'h0000_00AA, 32'h0};
        vecs[4] = '{ALU_SLL,  32'd1,          32'd31,     32'h8000_0000};
        vecs[5] = '{ALU_SRAI, 32'h8000_0000,  32'd4,      32'hF800_0000};
        vecs[6] = '{ALU_XOR,  32'h0000_1234,  32'h0,      32'h0000_1234};
        vecs[7] = '{ALU_ADDI, 32'hFFFF_FFFF,  32'd1,      32'h0};
        for (int i = 0; i < 8; i++) begin
            valid_i = 1'b1; ctrl = vecs[i].op; d1 = vecs[i].a; d2 = vecs[i].b;
            tick();
            chk($sformatf("b2b[%0d] valid", i), W'(valid_o), 1);
            chk($sformatf("b2b[%0d] data", i), data, vecs[i].exp);
            chk($sformatf("b2b[%0d] zero", i), W'(zero), W'(vecs[i].exp == '0));
        end
        valid_i = 1'b0;
        tick();
        chk("b2b idle valid", W'(valid_o), 0);

        // 3: MUL with requests arriving while busy
        valid_i = 1'b1; ctrl = ALU_MUL; d1 = 32'h0001_0003; d2 = 32'h0000_0005;
        tick();
        valid_i = 1'b0;
        pulses = 0; vcyc = 0; nrdy = 0;
        for (int c = 1; c <= 45; c++) begin
            if (!ready) nrdy++;
            if (valid_o) begin pulses++; vcyc = c; end
            if (c >= 5 && c <= 10) begin
                valid_i = 1'b1; ctrl = ALU_ADD; d1 = 32'd1; d2 = 32'd1;
            end else begin
                valid_i = 1'b0;
            end
            tick();
        end
        chk("mul pulses", pulses, 1);
        chk("mul valid cycle", vcyc, W + 1);
        chk("mul ready low", nrdy, W + 1);
        chk("mul data", data, 32'h0005_000F);

        // 5: flush mid-multiply, then flush together with a request
        prev = data;
        valid_i = 1'b1; ctrl = ALU_MUL; d1 = 32'd3; d2 = 32'd4;
        tick();
        valid_i = 1'b0;
        for (int c = 0; c < 9; c++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush ready", W'(ready), 1);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            if (valid_o) pulses++;
            tick();
        end
        chk("flush no result", pulses, 0);
        chk("flush data kept", data, prev);
        valid_i = 1'b1; ctrl = ALU_ADD; d1 = 32'd9; d2 = 32'd9; flush = 1'b1;
        tick();
        valid_i = 1'b0; flush = 1'b0;
        chk("flush+valid no accept", W'(valid_o), 0);
        tick();
        chk("flush+valid still idle", W'(valid_o), 0);
        chk("flush+valid data kept", data, prev);

        // 6: reset mid-multiply
        valid_i = 1'b1; ctrl = ALU_MUL; d1 = 32'd7; d2 = 32'd9;
        tick();
        valid_i = 1'b0;
        for (int c = 0; c < 19; c++) tick();
        #3 rst = 1'b1;
        #1;
        chk("mulrst valid_o", W'(valid_o), 0);
        chk("mulrst data_o", data, 0);
        chk("mulrst zero_o", W'(zero), 1);
        chk("mulrst ready_o", W'(ready), 1);
        @(posedge clk); #1 rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            if (valid_o) pulses++;
            tick();
        end
        chk("mulrst no result", pulses, 0);
        do_op(ALU_ADD, 32'd2, 32'd2, "post-reset add");

        // 4: MUL wrap and zero
        do_op(ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul wrap");
        do_op(ALU_MUL, 32'h0, 32'h0000_1234, "mul zero");

        // randomized ops against the reference model
        for (int i = 0; i < 150; i++) begin
            logic [2:0]   op;
            logic [W-1:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 40)) : $urandom;
            do_op(op, a, b, $sformatf("rnd[%0d] op%0d", i, op));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
